// File: rtl/uart_pkg.sv
// Shared definitions for the 8-bit asynchronous serial link (receiver today,
// transmitter when it is refactored).
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK_WAIT
   } uart_state_e;

   // 50 MHz / 115200 baud
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte handshake between the serial receiver and its consumer.
interface uart_rx_if #(
   parameter int unsigned DATA_BITS = 8
) ();

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ack;
   logic                 frame_err;
   logic                 overrun;

   modport master (
      output rx_data,
      output rx_valid,
      output frame_err,
      output overrun,
      input  rx_ack
   );

   modport slave (
      input  rx_data,
      input  rx_valid,
      input  frame_err,
      input  overrun,
      output rx_ack
   );

endinterface

// File: rtl/uart_rx_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input; both stages reset to
// RESET_VAL so an idle line does not look like an edge on reset release.
module bit_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[0], d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {2{RESET_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// Asynchronous serial receiver: mid-bit sampling, stop-bit check and a
// valid/ack handshake towards the consumer.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned CNT_MSB      = 9,
   parameter int unsigned DATA_BITS    = 8
) (
   input  logic       CLOCK_50,
   input  logic       rst_n,
   input  logic       rx_in,
   output logic       busy,
   uart_rx_if.master  rx_bus
);

   localparam int unsigned CW = CNT_MSB + 1;
   localparam int unsigned BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   logic rx_s;

   uart_state_e          state_q,     state_d;
   logic [CW-1:0]        cnt_q,       cnt_d;
   logic [BW-1:0]        bit_idx_q,   bit_idx_d;
   logic [DATA_BITS-1:0] shift_q,     shift_d;
   logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
   logic                 rx_valid_q,  rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q,   overrun_d;
   logic                 load;

   bit_sync #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (CLOCK_50),
      .rst_n (rst_n),
      .d     (rx_in),
      .q     (rx_s)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      load        = 1'b0;

      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d     = '0;
               shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 1'b1;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = STOP;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  load      = 1'b1;
                  rx_data_d = shift_q;
                  overrun_d = rx_valid_q && !rx_bus.rx_ack;
                  state_d   = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK_WAIT;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BREAK_WAIT: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A load takes priority over an ack landing in the same cycle.
      rx_valid_d = load ? 1'b1 : (rx_valid_q && !rx_bus.rx_ack);
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign busy             = (state_q != IDLE);
   assign rx_bus.rx_data   = rx_data_q;
   assign rx_bus.rx_valid  = rx_valid_q;
   assign rx_bus.frame_err = frame_err_q;
   assign rx_bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit: frames, overrun, break,
// glitch rejection, ack/load collision and mid-frame reset.
module tb_uart_rx;

   logic CLOCK_50 = 1'b0;
   logic rst_n    = 1'b0;
   logic rx_in    = 1'b1;
   logic busy;

   int total = 0;
   int bad   = 0;

   int fe_cnt    = 0;
   int ov_cnt    = 0;
   int busy_low  = 0;
   int busy_seen = 0;
   int fe_base   = 0;
   int ov_base   = 0;
   logic valid_prev = 1'b0;
   longint start_t  = 0;
   longint rise_t   = 0;
   longint lat      = 0;

   uart_rx_if #(.DATA_BITS(8)) rx_bus ();

   uart_rx #(
      .CLKS_PER_BIT (8),
      .CNT_MSB      (9),
      .DATA_BITS    (8)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .rx_in    (rx_in),
      .busy     (busy),
      .rx_bus   (rx_bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Pulse counters and rx_valid rise time, sampled away from the active edge.
   always @(negedge CLOCK_50) begin
      if (rx_bus.frame_err === 1'b1) fe_cnt = fe_cnt + 1;
      if (rx_bus.overrun === 1'b1) ov_cnt = ov_cnt + 1;
      if (rx_bus.rx_valid === 1'b1 && valid_prev !== 1'b1) rise_t = $time;
      valid_prev = rx_bus.rx_valid;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge CLOCK_50);
   endtask

   // One 80-cycle frame; optional ack on the load cycle, optional reset at cycle rst_at.
   task automatic send(input logic [7:0] b, input logic stop_bit, input bit ack_at_load,
                       input int rst_at);
      logic [9:0] fr;
      fr       = {stop_bit, b, 1'b0};
      busy_low = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge CLOCK_50);
         if (i == rst_at) begin
            rst_n = 1'b0;
            break;
         end
         if (i == 0) start_t = $time;
         if (i >= 3 && i <= 78 && busy !== 1'b1) busy_low = busy_low + 1;
         rx_in         = fr[i/8];
         rx_bus.rx_ack = ack_at_load && (i == 78);
      end
   endtask

   task automatic ack_pulse();
      @(negedge CLOCK_50);
      rx_bus.rx_ack = 1'b1;
      @(negedge CLOCK_50);
      rx_bus.rx_ack = 1'b0;
   endtask

   initial begin
      rx_bus.rx_ack = 1'b0;
      idle(3);
      check("reset_data",  32'(rx_bus.rx_data), 32'h00);
      check("reset_valid", 32'(rx_bus.rx_valid), 32'h0);
      check("reset_busy",  32'(busy), 32'h0);
      check("reset_ferr",  32'(rx_bus.frame_err), 32'h0);
      check("reset_ovr",   32'(rx_bus.overrun), 32'h0);
      rst_n = 1'b1;
      idle(4);

      fe_base = fe_cnt;
      ov_base = ov_cnt;
      send(8'hA5, 1'b1, 1'b0, -1);
      idle(2);
      lat = (rise_t - start_t) / 10;
      check("a5_valid", 32'(rx_bus.rx_valid), 32'h1);
      check("a5_data",  32'(rx_bus.rx_data), 32'hA5);
      check("a5_latency_in_78_80", 32'((lat >= 78) && (lat <= 80)), 32'h1);
      check("a5_busy_low_cycles", 32'(busy_low), 32'h0);
      check("a5_ferr_pulses", 32'(fe_cnt - fe_base), 32'h0);
      check("a5_ovr_pulses",  32'(ov_cnt - ov_base), 32'h0);

      ack_pulse();
      idle(1);
      check("a5_ack_clears", 32'(rx_bus.rx_valid), 32'h0);

      ov_base = ov_cnt;
      send(8'h3C, 1'b1, 1'b0, -1);
      send(8'hC3, 1'b1, 1'b0, -1);
      idle(2);
      check("b2b_ovr_pulses", 32'(ov_cnt - ov_base), 32'h1);
      check("b2b_data",  32'(rx_bus.rx_data), 32'hC3);
      check("b2b_valid", 32'(rx_bus.rx_valid), 32'h1);

      ack_pulse();
      idle(1);
      check("c3_ack_clears", 32'(rx_bus.rx_valid), 32'h0);

      fe_base = fe_cnt;
      send(8'h55, 1'b0, 1'b0, -1);
      idle(40);
      check("break_busy_held", 32'(busy), 32'h1);
      check("break_valid", 32'(rx_bus.rx_valid), 32'h0);
      rx_in = 1'b1;
      idle(5);
      check("break_ferr_once", 32'(fe_cnt - fe_base), 32'h1);
      check("break_idle_after_rise", 32'(busy), 32'h0);
      check("break_data_kept", 32'(rx_bus.rx_data), 32'hC3);

      send(8'h0F, 1'b1, 1'b0, -1);
      idle(2);
      check("0f_data",  32'(rx_bus.rx_data), 32'h0F);
      check("0f_valid", 32'(rx_bus.rx_valid), 32'h1);
      ack_pulse();
      idle(2);

      fe_base = fe_cnt;
      ov_base = ov_cnt;
      busy_seen = 0;
      @(negedge CLOCK_50);
      rx_in = 1'b0;
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);
      rx_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLOCK_50);
         if (busy === 1'b1) busy_seen = busy_seen + 1;
      end
      check("glitch_reached_start", 32'(busy_seen > 0), 32'h1);
      check("glitch_back_idle", 32'(busy), 32'h0);
      check("glitch_valid", 32'(rx_bus.rx_valid), 32'h0);
      check("glitch_pulses", 32'((fe_cnt - fe_base) + (ov_cnt - ov_base)), 32'h0);

      send(8'h66, 1'b1, 1'b0, -1);
      idle(2);
      ov_base = ov_cnt;
      send(8'h81, 1'b1, 1'b1, -1);
      idle(2);
      check("ackload_valid", 32'(rx_bus.rx_valid), 32'h1);
      check("ackload_data",  32'(rx_bus.rx_data), 32'h81);
      check("ackload_no_ovr", 32'(ov_cnt - ov_base), 32'h0);

      ack_pulse();
      idle(1);
      check("81_ack_clears", 32'(rx_bus.rx_valid), 32'h0);

      fe_base = fe_cnt;
      ov_base = ov_cnt;
      send(8'hFF, 1'b1, 1'b0, 40);
      #1;
      check("midreset_data",  32'(rx_bus.rx_data), 32'h00);
      check("midreset_valid", 32'(rx_bus.rx_valid), 32'h0);
      check("midreset_busy",  32'(busy), 32'h0);
      check("midreset_ferr",  32'(rx_bus.frame_err), 32'h0);
      check("midreset_ovr",   32'(rx_bus.overrun), 32'h0);
      rx_in = 1'b1;
      idle(3);
      rst_n = 1'b1;
      idle(3);
      send(8'h12, 1'b1, 1'b0, -1);
      idle(2);
      check("post_reset_data",  32'(rx_bus.rx_data), 32'h12);
      check("post_reset_valid", 32'(rx_bus.rx_valid), 32'h1);
      check("post_reset_pulses", 32'((fe_cnt - fe_base) + (ov_cnt - ov_base)), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
